// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) feeding a small byte FIFO with a valid/ready read port.
// Framing errors and dropped-on-full bytes are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rxd,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_frame_err,
  output logic                     o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

  // States: IDLE wait start | START mid-start check | DATA 8 bits | STOP stop check | BREAK wait line high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_sync1, r_sync2;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]     r_idx, w_idx_nxt;
  logic [7:0]     r_shreg, w_shreg_nxt;
  logic           w_push, w_ferr;

  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_frame_err, r_overrun;
  logic           w_pop, w_full, w_wr_en, w_drop;

  // Sync flops reset high so a low line during reset is not seen as a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          if (!r_sync2) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_shreg_nxt[r_idx] = r_sync2;
          w_cnt_nxt          = '0;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_nxt   = r_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          if (r_sync2) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (r_sync2) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop   = o_valid && i_ready;
  assign w_full  = (r_count == FULL);
  // When full, a same-cycle pop frees the slot the write pointer already points at.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_drop;
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= r_shreg;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data      = r_mem[r_rd_ptr];
  assign o_valid     = (r_count != '0);
  assign o_count     = r_count;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a negedge monitor
// pops and compares on every handshake and tallies error pulses.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_count(count), .o_frame_err(frame_err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, valid_cycles = 0, pop_cnt = 0;
  int t_valid_rise = 0, t_ovr = 0;
  logic prev_valid = 1'b0;
  logic [7:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) begin
        ovr_cnt++;
        t_ovr = cyc;
      end
      if (valid) begin
        valid_cycles++;
        if (!prev_valid) t_valid_rise = cyc;
      end
      prev_valid = valid;
      if (valid && ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_data", data, mon_exp);
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  int t0, v0, f0, o0, p0;

  initial begin
    rst = 1'b1; rxd = 1'b0; ready = 1'b0;
    repeat (3) tick();
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rxd = 1'b1; rst = 1'b0;
    idle(30);
    check("post_rst_no_valid", valid_cycles, 0);
    check("post_rst_no_ferr", ferr_cnt, 0);

    // 1: single byte, latency and single-cycle VALID
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    v0 = valid_cycles; t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check_range("t1_latency", t_valid_rise - t0, 154, 156);
    check("t1_valid_cycles", valid_cycles - v0, 1);
    check("t1_count", count, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: framing error then good byte
    f0 = ferr_cnt; v0 = valid_cycles;
    send_frame(8'h3C, 1'b0);
    idle(30);
    check("t2_ferr_once", ferr_cnt - f0, 1);
    check("t2_no_valid", valid_cycles - v0, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("t2_q_empty", exp_q.size(), 0);
    check("t2_valid_cycles", valid_cycles - v0, 1);

    // 3: start glitch rejected
    f0 = ferr_cnt; v0 = valid_cycles;
    rxd = 1'b0;
    repeat (4) tick();
    idle(40);
    check("t3_no_ferr", ferr_cnt - f0, 0);
    check("t3_no_valid", valid_cycles - v0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("t3_q_empty", exp_q.size(), 0);
    check("t3_valid_cycles", valid_cycles - v0, 1);

    // 4: overrun on fifth byte
    ready = 1'b0; o0 = ovr_cnt;
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    for (int k = 1; k <= 5; k++) begin
      t0 = cyc;
      send_frame(8'(k), 1'b1);
      if (k == 4) check("t4_count4", count, 4);
    end
    check("t4_ovr_once", ovr_cnt - o0, 1);
    check_range("t4_ovr_time", t_ovr - t0, 154, 156);
    check("t4_count_full", count, 4);
    idle(10);
    p0 = pop_cnt;
    ready = 1'b1;
    repeat (4) tick();
    check("t4_pops_consecutive", pop_cnt - p0, 4);
    check("t4_valid_low", valid, 0);
    check("t4_count0", count, 0);
    check("t4_q_empty", exp_q.size(), 0);
    idle(5);

    // 5: push and pop on the same cycle when full
    ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1);
    end
    exp_q.push_back(8'h55);
    check("t5_count4", count, 4);
    o0 = ovr_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (CPB * 10 - 6) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
    join
    check("t5_no_ovr", ovr_cnt - o0, 0);
    check("t5_count_stays4", count, 4);
    check("t5_q_left", exp_q.size(), 4);
    ready = 1'b1;
    idle(6);
    check("t5_count0", count, 0);
    check("t5_q_empty", exp_q.size(), 0);

    // 6: reset mid-frame flushes FIFO and loses the partial byte
    ready = 1'b0;
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22); send_frame(8'h22, 1'b1);
    check("t6_count2", count, 2);
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("t6_count0", count, 0);
    check("t6_valid0", valid, 0);
    v0 = valid_cycles;
    idle(CPB * 5 + 20);
    check("t6_no_ferr", ferr_cnt - f0, 0);
    check("t6_no_ovr", ovr_cnt - o0, 0);
    check("t6_no_byte", valid_cycles - v0, 0);
    ready = 1'b1;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(20);
    check("t6_valid_cycles", valid_cycles - v0, 1);
    check("end_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
